// File: rtl/inst_fetch_aligner.sv
// Instruction fetch aligner: a two-entry buffer of 64-bit fetch words with a single-outstanding
// refill port. Returns the RV64C instruction at pc, including 32-bit ones straddling two words.
module inst_fetch_aligner #(
    parameter int RESET_FILL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc,
    input  logic        flush,
    output logic        inst_valid,
    output logic        inst_compressed,
    output logic [31:0] inst,
    output logic        request,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    // RESET_FILL is reserved: a miss right after reset starts a fill with either setting.
    localparam logic FILL_EN = 1'b1 | (RESET_FILL != 0);

    state_t      state_reg;
    logic        mem_req_reg;
    logic [63:0] mem_addr_reg;
    logic        entry_valid_reg [2];
    logic [60:0] entry_tag_reg   [2];
    logic [63:0] entry_data_reg  [2];

    logic [60:0] lo_word;
    logic [60:0] hi_word;
    logic [1:0]  half_idx;
    logic [1:0]  lo_hit_vec;
    logic [1:0]  hi_hit_vec;
    logic [1:0]  keep_vec;
    logic [1:0]  fill_vec;
    logic        lo_hit;
    logic        hi_hit;
    logic [63:0] lo_data;
    logic [63:0] hi_data;
    logic [15:0] lo_half;
    logic [15:0] next_half;
    logic        is_32;
    logic        straddle;
    logic        complete;
    logic        miss_needed;
    logic [60:0] miss_word;
    logic        fill_en;
    logic        fill_sel;
    logic        unused_pc_bit;

    assign unused_pc_bit = pc[0];
    assign lo_word  = pc[63:3];
    assign hi_word  = lo_word + 61'd1;
    assign half_idx = pc[2:1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            assign lo_hit_vec[gi] = entry_valid_reg[gi] && (entry_tag_reg[gi] == lo_word);
            assign hi_hit_vec[gi] = entry_valid_reg[gi] && (entry_tag_reg[gi] == hi_word);
            // An entry is worth keeping if it holds a word the current pc still needs.
            assign keep_vec[gi]   = lo_hit_vec[gi] || ((half_idx == 2'd3) && hi_hit_vec[gi]);
            assign fill_vec[gi]   = fill_en && (fill_sel == 1'(gi));
        end
    endgenerate

    assign lo_hit  = |lo_hit_vec;
    assign hi_hit  = |hi_hit_vec;
    assign lo_data = lo_hit_vec[1] ? entry_data_reg[1] : entry_data_reg[0];
    assign hi_data = hi_hit_vec[1] ? entry_data_reg[1] : entry_data_reg[0];
    assign lo_half = lo_data[{half_idx, 4'b0000} +: 16];

    always_comb begin
        next_half = hi_data[15:0];
        if (half_idx != 2'd3) begin
            next_half = lo_data[{half_idx + 2'd1, 4'b0000} +: 16];
        end
    end

    assign is_32       = (lo_half[1:0] == 2'b11);
    assign straddle    = is_32 && (half_idx == 2'd3);
    assign complete    = lo_hit && (!straddle || hi_hit);
    assign miss_needed = !lo_hit || (straddle && !hi_hit);
    assign miss_word   = lo_hit ? hi_word : lo_word;

    assign inst_valid      = complete && (state_reg != DROP) && !flush;
    // Gate with inst_valid so idle/reset outputs read as zero rather than stale buffer bits.
    assign inst_compressed = inst_valid && !is_32;
    assign inst            = !inst_valid ? 32'h0000_0000 :
                             is_32       ? {next_half, lo_half} : {16'h0000, lo_half};

    assign request  = (state_reg != IDLE);
    assign mem_req  = mem_req_reg && !flush;
    assign mem_addr = mem_addr_reg;

    assign fill_en = (state_reg == WAIT) && mem_rvalid && !flush;

    always_comb begin
        fill_sel = 1'b0;
        if (keep_vec[0]) begin
            fill_sel = 1'b1;
        end else if (keep_vec[1]) begin
            fill_sel = 1'b0;
        end else if (!entry_valid_reg[0]) begin
            fill_sel = 1'b0;
        end else if (!entry_valid_reg[1]) begin
            fill_sel = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss_needed && !flush && FILL_EN) begin
                        state_reg    <= REQ;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= {miss_word, 3'b000};
                    end
                end
                REQ: begin
                    // A flush withdraws the request before it can be accepted.
                    if (flush) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                    end else if (mem_ready) begin
                        state_reg   <= WAIT;
                        mem_req_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_reg <= IDLE;
                    end else if (flush) begin
                        state_reg <= DROP;
                    end
                end
                default: begin
                    if (mem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                entry_valid_reg[i] <= 1'b0;
                entry_tag_reg[i]   <= '0;
                entry_data_reg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (flush) begin
                    entry_valid_reg[i] <= 1'b0;
                end else if (fill_vec[i]) begin
                    entry_valid_reg[i] <= 1'b1;
                    entry_tag_reg[i]   <= mem_addr_reg[63:3];
                    entry_data_reg[i]  <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_aligner.sv
// Bench for inst_fetch_aligner: directed scenarios then randomized pc/flush/ready/latency traffic,
// checked every cycle against a memory-image reference of the expected instruction stream.
module tb_inst_fetch_aligner;

    localparam int IDLE_P = 0;
    localparam int REQ_P  = 1;
    localparam int WAIT_P = 2;
    localparam int DROP_P = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc = '0;
    logic        flush = 1'b0;
    logic        inst_valid;
    logic        inst_compressed;
    logic [31:0] inst;
    logic        request;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    inst_fetch_aligner #(.RESET_FILL(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .flush           (flush),
        .inst_valid      (inst_valid),
        .inst_compressed (inst_compressed),
        .inst            (inst),
        .request         (request),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    // memory responder
    int          mem_cnt = 0;
    logic [60:0] mem_word = '0;
    bit          stale = 1'b0;
    bit          outstanding = 1'b0;
    bit          rand_lat = 1'b0;
    int          accepts = 0;

    // reference model: which words the two buffer slots hold, and the refill phase
    int          phase = IDLE_P;
    bit          m_valid [2];
    logic [60:0] m_tag   [2];
    logic [60:0] pend = '0;

    // values seen in the most recent cycle
    logic        obs_valid;
    logic        obs_comp;
    logic        obs_req;
    logic [31:0] obs_inst;
    logic [63:0] obs_addr;
    bit          exp_valid_q;
    bit          exp_is32_q;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h required=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] word_at(input logic [60:0] w);
        logic [63:0] x;
        if (w == 61'd0) return 64'h0093_4505_0010_0513;
        if (w == 61'd1) return 64'h0000_0000_0000_0010;
        x = {3'b000, w} * 64'h9E37_79B9_7F4A_7C15;
        x = x ^ (x >> 29);
        return x;
    endfunction

    function automatic logic [15:0] half_at(input logic [63:0] addr);
        logic [63:0] wd;
        wd = word_at(addr[63:3]);
        return wd[{addr[2:1], 4'b0000} +: 16];
    endfunction

    function automatic logic [31:0] expect_inst(input logic [63:0] a);
        logic [15:0] h0;
        h0 = half_at(a);
        if (h0[1:0] == 2'b11) return {half_at(a + 64'd2), h0};
        return {16'h0000, h0};
    endfunction

    function automatic bit cached(input logic [60:0] w);
        return (m_valid[0] && (m_tag[0] == w)) || (m_valid[1] && (m_tag[1] == w));
    endfunction

    task automatic model_step(input logic [63:0] a, input logic [63:0] a2, input bit is32,
                              input bit fl, input bit rdy, input bit rv);
        logic [60:0] lo;
        logic [60:0] nx;
        bit k0;
        bit k1;
        int vic;
        lo = a[63:3];
        nx = a2[63:3];
        case (phase)
            IDLE_P: begin
                if (!fl) begin
                    if (!cached(lo)) begin
                        phase = REQ_P;
                        pend  = lo;
                    end else if (is32 && !cached(nx)) begin
                        phase = REQ_P;
                        pend  = nx;
                    end
                end
            end
            REQ_P: begin
                if (fl) phase = IDLE_P;
                else if (rdy) phase = WAIT_P;
            end
            WAIT_P: begin
                if (rv) begin
                    if (!fl) begin
                        k0 = m_valid[0] && ((m_tag[0] == lo) || (m_tag[0] == nx));
                        k1 = m_valid[1] && ((m_tag[1] == lo) || (m_tag[1] == nx));
                        if (k0) vic = 1;
                        else if (k1) vic = 0;
                        else if (!m_valid[0]) vic = 0;
                        else if (!m_valid[1]) vic = 1;
                        else vic = 0;
                        m_valid[vic] = 1'b1;
                        m_tag[vic]   = pend;
                    end
                    phase = IDLE_P;
                end else if (fl) begin
                    phase = DROP_P;
                end
            end
            default: begin
                if (rv) phase = IDLE_P;
            end
        endcase
        if (fl) begin
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
        end
    endtask

    task automatic cycle(input logic [63:0] p, input logic fl, input logic rdy);
        logic [63:0] a;
        logic [63:0] a2;
        logic [15:0] h0;
        bit is32;
        bit complete;
        @(negedge clk);
        rst_n      = 1'b1;
        pc         = p;
        flush      = fl;
        mem_ready  = rdy;
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom};
        if (stale) begin
            mem_rvalid = 1'b1;
            stale      = 1'b0;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_rvalid  = 1'b1;
                mem_rdata   = word_at(mem_word);
                outstanding = 1'b0;
            end
        end
        #1;
        a  = {p[63:1], 1'b0};
        a2 = a + 64'd2;
        h0 = half_at(a);
        is32 = (h0[1:0] == 2'b11);
        complete = cached(a[63:3]) && (!is32 || cached(a2[63:3]));
        exp_valid_q = complete && (phase != DROP_P) && !fl;
        exp_is32_q  = is32;
        obs_valid = inst_valid;
        obs_comp  = inst_compressed;
        obs_inst  = inst;
        obs_req   = mem_req;
        obs_addr  = mem_addr;
        check_eq("inst_valid", 64'(inst_valid), 64'(exp_valid_q));
        if (exp_valid_q) begin
            check_eq("inst", 64'(inst), 64'(expect_inst(a)));
            check_eq("inst_compressed", 64'(inst_compressed), 64'(!is32));
        end
        check_eq("request", 64'(request), 64'(phase != IDLE_P));
        check_eq("mem_req", 64'(mem_req), 64'((phase == REQ_P) && !fl));
        if (phase == REQ_P) check_eq("mem_addr", mem_addr, {pend, 3'b000});
        if (mem_req && mem_ready) begin
            check_eq("single_outstanding", 64'(outstanding), 64'd0);
            accepts++;
            outstanding = 1'b1;
            mem_word = mem_addr[63:3];
            mem_cnt  = rand_lat ? int'($urandom_range(4, 1)) : 3;
            $display("t=%0t read addr=%h latency=%0d", $time, mem_addr, mem_cnt);
        end
        @(posedge clk);
        model_step(a, a2, is32, fl, rdy, mem_rvalid);
    endtask

    task automatic apply_reset(input int hold);
        @(negedge clk);
        rst_n      = 1'b0;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        if (mem_cnt > 0) stale = 1'b1;
        mem_cnt     = 0;
        outstanding = 1'b0;
        phase       = IDLE_P;
        m_valid[0]  = 1'b0;
        m_valid[1]  = 1'b0;
        #1;
        check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_inst_compressed", 64'(inst_compressed), 64'd0);
        check_eq("rst_inst", 64'(inst), 64'd0);
        check_eq("rst_request", 64'(request), 64'd0);
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        repeat (hold) @(posedge clk);
    endtask

    task automatic run_until_valid(input logic [63:0] p, input string tag);
        int n;
        n = 0;
        do begin
            cycle(p, 1'b0, 1'b1);
            n++;
        end while (!obs_valid && n < 40);
        check_eq(tag, 64'(obs_valid), 64'd1);
    endtask

    function automatic logic [63:0] random_pc();
        if ($urandom_range(1, 0) == 1) return 64'($urandom_range(1023, 0));
        return 64'hFFFF_FFFF_FFFF_FF80 + 64'($urandom_range(127, 0));
    endfunction

    initial begin
        logic [63:0] p;
        int acc_before;
        int r;
        bit fl;
        bit rdy;

        apply_reset(2);

        run_until_valid(64'h0, "tp_fill0");
        check_eq("tp_inst0", 64'(obs_inst), 64'h0010_0513);
        check_eq("tp_comp0", 64'(obs_comp), 64'd0);

        cycle(64'h4, 1'b0, 1'b1);
        check_eq("tp_hit4_valid", 64'(obs_valid), 64'd1);
        check_eq("tp_hit4_inst", 64'(obs_inst), 64'h0000_4505);
        check_eq("tp_hit4_comp", 64'(obs_comp), 64'd1);
        check_eq("tp_hit4_nomemreq", 64'(obs_req), 64'd0);

        cycle(64'h6, 1'b0, 1'b1);
        check_eq("tp_straddle_addr", obs_addr, 64'h0);
        cycle(64'h6, 1'b0, 1'b1);
        check_eq("tp_straddle_req_addr", obs_addr, 64'h8);
        run_until_valid(64'h6, "tp_fill6");
        check_eq("tp_inst6", 64'(obs_inst), 64'h0010_0093);
        check_eq("tp_comp6", 64'(obs_comp), 64'd0);
        cycle(64'h0, 1'b0, 1'b1);
        check_eq("tp_word0_kept", 64'(obs_valid), 64'd1);

        acc_before = accepts;
        cycle(64'h100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(64'h100, 1'b0, 1'b0);
            check_eq("tp_stall_req", 64'(obs_req), 64'd1);
            check_eq("tp_stall_addr", obs_addr, 64'h100);
        end
        run_until_valid(64'h100, "tp_fill100");
        check_eq("tp_one_accept", 64'(accepts - acc_before), 64'd1);

        cycle(64'h200, 1'b0, 1'b1);
        cycle(64'h200, 1'b0, 1'b1);
        cycle(64'h200, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(64'h200, 1'b0, 1'b1);
            check_eq("tp_drop_novalid", 64'(obs_valid), 64'd0);
        end
        cycle(64'h200, 1'b0, 1'b1);
        check_eq("tp_refetch_req", 64'(obs_req), 64'd1);
        check_eq("tp_refetch_addr", obs_addr, 64'h200);
        run_until_valid(64'h200, "tp_fill200");

        cycle(64'h300, 1'b0, 1'b1);
        cycle(64'h300, 1'b0, 1'b1);
        cycle(64'h300, 1'b0, 1'b1);
        apply_reset(2);
        cycle(64'h300, 1'b0, 1'b1);
        check_eq("tp_stale_novalid", 64'(obs_valid), 64'd0);
        cycle(64'h300, 1'b0, 1'b1);
        check_eq("tp_rst_req", 64'(obs_req), 64'd1);
        check_eq("tp_rst_addr", obs_addr, 64'h300);
        run_until_valid(64'h300, "tp_fill300");
        check_eq("tp_rst_inst", 64'(obs_inst), 64'(expect_inst(64'h300)));

        rand_lat = 1'b1;
        p = 64'h300;
        for (int i = 0; i < 4000; i++) begin
            fl  = ($urandom_range(99, 0) < 3);
            rdy = ($urandom_range(99, 0) < 70);
            cycle(p, fl, rdy);
            if (exp_valid_q) begin
                r = int'($urandom_range(99, 0));
                if (r < 5) p = random_pc();
                else if (r < 85) p = p + (exp_is32_q ? 64'd4 : 64'd2);
            end
            if (i % 1500 == 777) apply_reset(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
